// File: rtl/wb_mem_responder.sv
// Purpose : single-port 32-bit word memory answering cyc/stb/ack bus requests
//           with WAIT_STATES wait cycles, byte-lane writes, and a one-cycle ack.
// Latency : stb sampled at edge N -> ack_o high during the cycle after edge N+WAIT_STATES.
// Backpr. : no queueing; stb_i is ignored outside IDLE, and a transfer is aborted if cyc_i drops in WAIT.
// Ports   : clk, rst (async active-low); cyc_i/stb_i/we_i/adr_i/sel_i/dat_i request;
//           dat_o/ack_o response; busy_o = not IDLE.
// Option  : define WB_MEM_ERR_EN to add err_o, pulsed instead of ack_o for
//           addresses outside [MEM_BASE, MEM_BASE + 4*2**ADDR_W). Legal ADDR_W is 1..29.
module wb_mem_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
`ifdef WB_MEM_ERR_EN
    output logic        err_o,
`endif
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        busy_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic                we_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [3:0]          sel_q;
    logic [31:0]         dat_q;
    logic [31:0]         mem [DEPTH];

    logic [ADDR_W-1:0]   req_idx;
    logic                accept;
    logic                enter_ack;

    // Transaction fields seen on the edge that enters ACK. With zero wait
    // states that edge is the accepting edge, so take them from the bus.
    logic                x_we;
    logic [ADDR_W-1:0]   x_idx;
    logic [3:0]          x_sel;
    logic [31:0]         x_dat;
    logic                x_err;

    // Word index with wrap-around: the byte offset is shifted to words and
    // truncated, which also discards adr_i[1:0].
    assign req_idx   = ADDR_W'((adr_i - MEM_BASE) >> 2);
    assign accept    = (state == IDLE) && cyc_i && stb_i;
    assign enter_ack = (state != ACK) && (state_nxt == ACK);

`ifdef WB_MEM_ERR_EN
    logic req_oor;
    logic err_q;
    assign req_oor = (adr_i < MEM_BASE) || (((adr_i - MEM_BASE) >> (ADDR_W + 2)) != '0);
    assign x_err   = (state == IDLE) ? req_oor : err_q;
`else
    assign x_err   = 1'b0;
`endif

    always_comb begin
        x_we  = we_q;
        x_idx = idx_q;
        x_sel = sel_q;
        x_dat = dat_q;
        if (state == IDLE) begin
            x_we  = we_i;
            x_idx = req_idx;
            x_sel = sel_i;
            x_dat = dat_i;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic. WAIT exits to ACK on the edge where the counter
    // reaches zero, so WAIT lasts exactly WAIT_STATES cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cyc_i && stb_i) state_nxt = (WAIT_STATES == 0) ? ACK : WAIT;
            WAIT: begin
                if (!cyc_i)          state_nxt = IDLE;
                else if (cnt <= 4'd1) state_nxt = ACK;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_o = (state != IDLE);
    end

    // Request latch, wait counter and registered response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= 4'd0;
            we_q  <= 1'b0;
            idx_q <= '0;
            sel_q <= 4'd0;
            dat_q <= 32'd0;
            ack_o <= 1'b0;
            dat_o <= 32'd0;
`ifdef WB_MEM_ERR_EN
            err_q <= 1'b0;
            err_o <= 1'b0;
`endif
        end else begin
            if (accept) begin
                cnt   <= 4'(WAIT_STATES);
                we_q  <= we_i;
                idx_q <= req_idx;
                sel_q <= sel_i;
                dat_q <= dat_i;
`ifdef WB_MEM_ERR_EN
                err_q <= req_oor;
`endif
            end else if (state_nxt == WAIT) begin
                cnt <= cnt - 4'd1;
            end else begin
                cnt <= 4'd0;
            end

            ack_o <= enter_ack && !x_err;
`ifdef WB_MEM_ERR_EN
            err_o <= enter_ack && x_err;
`endif
            if (enter_ack) begin
                if (x_err)      dat_o <= 32'd0;
                else if (!x_we) dat_o <= mem[x_idx];
            end
        end
    end

    // Memory array, not reset. The rst term drops a commit that would
    // otherwise land on an edge while reset is held.
    always_ff @(posedge clk) begin
        if (rst && enter_ack && x_we && !x_err) begin
            for (int b = 0; b < 4; b++) begin
                if (x_sel[b]) mem[x_idx][8*b +: 8] <= x_dat[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench: three responders (WAIT_STATES 1, 0, 3; ADDR_W 4) on shared
// address/data lines with private cyc/stb. Inputs change on falling edges,
// outputs are sampled on falling edges.
module tb_wb_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  cyc, stb;
    logic        we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] rdat [3];
    logic [2:0]  ack, busy, err;

    int checks   = 0;
    int failures = 0;

    wb_mem_responder #(.ADDR_W(4), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we), .adr_i(adr),
        .sel_i(sel), .dat_i(wdat),
`ifdef WB_MEM_ERR_EN
        .err_o(err[0]),
`endif
        .dat_o(rdat[0]), .ack_o(ack[0]), .busy_o(busy[0]));

    wb_mem_responder #(.ADDR_W(4), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we), .adr_i(adr),
        .sel_i(sel), .dat_i(wdat),
`ifdef WB_MEM_ERR_EN
        .err_o(err[1]),
`endif
        .dat_o(rdat[1]), .ack_o(ack[1]), .busy_o(busy[1]));

    wb_mem_responder #(.ADDR_W(4), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we), .adr_i(adr),
        .sel_i(sel), .dat_i(wdat),
`ifdef WB_MEM_ERR_EN
        .err_o(err[2]),
`endif
        .dat_o(rdat[2]), .ack_o(ack[2]), .busy_o(busy[2]));

`ifndef WB_MEM_ERR_EN
    assign err = 3'b000;
`endif

    // One bus transfer on instance u. lat = falling edges from request to
    // response (0 if none within the budget), rd = dat_o at the response.
    task automatic do_xfer(input int u, input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd, output int lat, output logic e);
        @(negedge clk);
        cyc[u] = 1'b1; stb[u] = 1'b1; we = w; adr = a; sel = s; wdat = d;
        lat = 0; rd = '0; e = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            stb[u] = 1'b0;
            if (ack[u] || err[u]) begin
                lat = n; rd = rdat[u]; e = err[u];
                break;
            end
        end
        cyc[u] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; cyc = '0; stb = '0; we = 1'b0; adr = '0; sel = '0; wdat = '0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++; if (ack[u] !== 1'b0)  begin failures++; $display("FAIL reset_ack u%0d: got %b want 0", u, ack[u]); end
            checks++; if (busy[u] !== 1'b0) begin failures++; $display("FAIL reset_busy u%0d: got %b want 0", u, busy[u]); end
            checks++; if (rdat[u] !== 32'h0) begin failures++; $display("FAIL reset_dat u%0d: got %h want 0", u, rdat[u]); end
            checks++; if (err[u] !== 1'b0)  begin failures++; $display("FAIL reset_err u%0d: got %b want 0", u, err[u]); end
        end
        rst = 1'b1;
    endtask

    task automatic test_read_latency();
        logic [31:0] rd; int lat; logic e;
        do_xfer(0, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D, rd, lat, e);
        checks++; if (lat != 2) begin failures++; $display("FAIL preload_lat: got %0d want 2", lat); end
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF;
        @(negedge clk);
        stb[0] = 1'b0;
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL lat_busy_n1: got %b want 1", busy[0]); end
        checks++; if (ack[0] !== 1'b0)  begin failures++; $display("FAIL lat_ack_n1: got %b want 0", ack[0]); end
        @(negedge clk);
        checks++; if (ack[0] !== 1'b1)  begin failures++; $display("FAIL lat_ack_n2: got %b want 1", ack[0]); end
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL lat_busy_n2: got %b want 1", busy[0]); end
        checks++; if (rdat[0] !== 32'hCAFEF00D) begin failures++; $display("FAIL lat_dat: got %h want cafef00d", rdat[0]); end
        cyc[0] = 1'b0;
        @(negedge clk);
        checks++; if (ack[0] !== 1'b0)  begin failures++; $display("FAIL lat_ack_n3: got %b want 0", ack[0]); end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL lat_busy_n3: got %b want 0", busy[0]); end
        checks++; if (rdat[0] !== 32'hCAFEF00D) begin failures++; $display("FAIL lat_dat_hold: got %h want cafef00d", rdat[0]); end
    endtask

    task automatic test_byte_lane();
        logic [31:0] rd; int lat; logic e;
        do_xfer(0, 1'b1, 32'h8, 4'hF, 32'h11223344, rd, lat, e);
        do_xfer(0, 1'b1, 32'h8, 4'b0101, 32'hAABBCCDD, rd, lat, e);
        checks++; if (lat != 2) begin failures++; $display("FAIL lane_wr_lat: got %0d want 2", lat); end
        do_xfer(0, 1'b0, 32'h8, 4'hF, 32'h0, rd, lat, e);
        checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL lane_rd: got %h want 11bb33dd", rd); end
    endtask

    task automatic test_sel_zero();
        logic [31:0] rd; int lat; logic e;
        do_xfer(0, 1'b1, 32'hB, 4'b0000, 32'hFFFFFFFF, rd, lat, e);
        checks++; if (lat != 2) begin failures++; $display("FAIL sel0_ack_lat: got %0d want 2", lat); end
        do_xfer(0, 1'b0, 32'h8, 4'hF, 32'h0, rd, lat, e);
        checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL sel0_rd: got %h want 11bb33dd", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat; logic e; logic seen;
        do_xfer(2, 1'b1, 32'h0, 4'hF, 32'h01020304, rd, lat, e);
        checks++; if (lat != 4) begin failures++; $display("FAIL ws3_lat: got %0d want 4", lat); end
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we = 1'b1; adr = 32'h0; sel = 4'hF; wdat = 32'hDEADBEEF;
        @(negedge clk);
        stb[2] = 1'b0;
        checks++; if (busy[2] !== 1'b1) begin failures++; $display("FAIL abort_busy_wait: got %b want 1", busy[2]); end
        cyc[2] = 1'b0;
        @(negedge clk);
        checks++; if (busy[2] !== 1'b0) begin failures++; $display("FAIL abort_busy_idle: got %b want 0", busy[2]); end
        seen = ack[2];
        repeat (5) begin @(negedge clk); seen |= ack[2]; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_ack: got %b want 0", seen); end
        do_xfer(2, 1'b0, 32'h0, 4'hF, 32'h0, rd, lat, e);
        checks++; if (rd !== 32'h01020304) begin failures++; $display("FAIL abort_mem: got %h want 01020304", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat; logic e;
        do_xfer(1, 1'b1, 32'h14, 4'hF, 32'h12345678, rd, lat, e);
        checks++; if (lat != 1) begin failures++; $display("FAIL ws0_lat: got %0d want 1", lat); end
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; adr = 32'hC; sel = 4'hF; wdat = 32'h00000055;
        @(negedge clk);
        checks++; if (ack[1] !== 1'b1) begin failures++; $display("FAIL b2b_ack1: got %b want 1", ack[1]); end
        // strobe held high during ACK with a different write: must be dropped
        adr = 32'h14; wdat = 32'h00000077;
        @(negedge clk);
        checks++; if (ack[1] !== 1'b0)  begin failures++; $display("FAIL b2b_gap_ack: got %b want 0", ack[1]); end
        checks++; if (busy[1] !== 1'b0) begin failures++; $display("FAIL b2b_gap_busy: got %b want 0", busy[1]); end
        we = 1'b0; adr = 32'hC;
        @(negedge clk);
        checks++; if (ack[1] !== 1'b1) begin failures++; $display("FAIL b2b_ack2: got %b want 1", ack[1]); end
        checks++; if (rdat[1] !== 32'h00000055) begin failures++; $display("FAIL b2b_rd: got %h want 00000055", rdat[1]); end
        stb[1] = 1'b0; cyc[1] = 1'b0;
        @(negedge clk);
        checks++; if (ack[1] !== 1'b0) begin failures++; $display("FAIL b2b_ack_end: got %b want 0", ack[1]); end
        do_xfer(1, 1'b0, 32'h14, 4'hF, 32'h0, rd, lat, e);
        checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL b2b_ignored_wr: got %h want 12345678", rd); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; int lat; logic e; logic seen;
        do_xfer(2, 1'b1, 32'h4, 4'hF, 32'hA5A5A5A5, rd, lat, e);
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we = 1'b1; adr = 32'h4; sel = 4'hF; wdat = 32'hFFFF0000;
        @(negedge clk);
        stb[2] = 1'b0;
        checks++; if (busy[2] !== 1'b1) begin failures++; $display("FAIL arst_busy_pre: got %b want 1", busy[2]); end
        #2 rst = 1'b0;
        #1;
        checks++; if (busy[2] !== 1'b0) begin failures++; $display("FAIL arst_busy_now: got %b want 0", busy[2]); end
        checks++; if (ack[2] !== 1'b0)  begin failures++; $display("FAIL arst_ack_now: got %b want 0", ack[2]); end
        cyc[2] = 1'b0;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); seen |= ack[2]; end
        rst = 1'b1;
        repeat (5) begin @(negedge clk); seen |= ack[2]; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL arst_no_ack: got %b want 0", seen); end
        do_xfer(2, 1'b0, 32'h4, 4'hF, 32'h0, rd, lat, e);
        checks++; if (rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL arst_mem: got %h want a5a5a5a5", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; int lat; logic e;
        do_xfer(0, 1'b1, 32'h0, 4'hF, 32'h600DF00D, rd, lat, e);
`ifdef WB_MEM_ERR_EN
        do_xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat, e);
        checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL err_pre_rd: got %h want cafef00d", rd); end
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we = 1'b0; adr = 32'h40; sel = 4'hF;
        @(negedge clk);
        stb[0] = 1'b0;
        checks++; if (err[0] !== 1'b0) begin failures++; $display("FAIL err_early: got %b want 0", err[0]); end
        @(negedge clk);
        checks++; if (err[0] !== 1'b1) begin failures++; $display("FAIL err_pulse: got %b want 1", err[0]); end
        checks++; if (ack[0] !== 1'b0) begin failures++; $display("FAIL err_ack: got %b want 0", ack[0]); end
        checks++; if (rdat[0] !== 32'h0) begin failures++; $display("FAIL err_dat: got %h want 0", rdat[0]); end
        cyc[0] = 1'b0;
        @(negedge clk);
        checks++; if (err[0] !== 1'b0) begin failures++; $display("FAIL err_width: got %b want 0", err[0]); end
        do_xfer(0, 1'b1, 32'h40, 4'hF, 32'hFFFFFFFF, rd, lat, e);
        checks++; if (e !== 1'b1 || lat != 2) begin failures++; $display("FAIL err_wr: got e=%b lat=%0d want e=1 lat=2", e, lat); end
        do_xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, lat, e);
        checks++; if (rd !== 32'h600DF00D) begin failures++; $display("FAIL err_mem0: got %h want 600df00d", rd); end
`else
        do_xfer(0, 1'b1, 32'h40, 4'hF, 32'h0BADC0DE, rd, lat, e);
        checks++; if (lat != 2) begin failures++; $display("FAIL wrap_wr_lat: got %0d want 2", lat); end
        do_xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, lat, e);
        checks++; if (rd !== 32'h0BADC0DE) begin failures++; $display("FAIL wrap_rd0: got %h want 0badc0de", rd); end
        do_xfer(0, 1'b0, 32'h43, 4'hF, 32'h0, rd, lat, e);
        checks++; if (rd !== 32'h0BADC0DE) begin failures++; $display("FAIL wrap_rd43: got %h want 0badc0de", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_byte_lane();
        test_sel_zero();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_mem_responder.md
Name: wb_mem_responder

Overview:
- Memory-side responder for the CPU bus used by the instruction and data fetch FSMs (cyc/stb/ack).
- Accepts a one-cycle stb pulse qualified by cyc, inserts configurable wait states, then returns a single-cycle ack with read data or commits write data with byte lanes.
- One instance serves the instruction port and one serves the data port in the sim and FPGA top level.

Parameters:
- ADDR_W, 10, word-address width; depth = 2**ADDR_W 32-bit words.
- WAIT_STATES, 1, cycles spent in WAIT before ack; 0..15 legal.
- MEM_BASE, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- cyc_i  input  1  bus cycle active; must stay high until ack/err.
- stb_i  input  1  request strobe; may be a one-cycle pulse.
- we_i  input  1  1 = write, 0 = read; sampled with stb_i.
- adr_i  input  32  byte address; sampled with stb_i.
- sel_i  input  4  byte enables, bit n = dat[8n+7:8n]; sampled with stb_i.
- dat_i  input  32  write data; sampled with stb_i.
- dat_o  output  32  read data; valid in the ack cycle.
- ack_o  output  1  transfer complete, one-cycle pulse.
- busy_o  output  1  high when state != IDLE.

Behaviour:
- States: IDLE, WAIT, ACK. Reset forces IDLE, ack_o=0, dat_o=0, busy_o=0, wait counter=0. Memory array is not reset.
- IDLE:
  - If cyc_i & stb_i: latch we, adr, sel, dat.
  - Load counter = WAIT_STATES.
  - Go to WAIT, or directly to ACK when WAIT_STATES=0.
- WAIT:
  - Counter decrements each cycle; on reaching 0, go to ACK.
  - stb_i is ignored here (no queueing).
- Entering ACK (registered, same edge):
  - Read: dat_o <= mem[idx].
  - Write: for each sel bit set, mem[idx] byte lane <= latched dat; dat_o is unchanged.
  - ack_o <= 1.
- ACK: lasts exactly one cycle; ack_o returns to 0 and the next state is IDLE unconditionally. A stb_i seen during ACK is ignored, so there is always at least one IDLE cycle between transfers.
- Latency: stb sampled at edge N, ack_o high during cycle N+1+WAIT_STATES.
- Address index: idx = ((adr_i - MEM_BASE) >> 2) truncated to ADDR_W bits. adr_i[1:0] is ignored. Out-of-range addresses wrap modulo depth.
- Abort: if cyc_i is low in WAIT, go to IDLE with no ack and no memory write. dat_o holds its value.
- sel_i = 4'b0000 on a write: ack is still given and memory is unchanged.
- Reset asserted mid-transfer: immediate return to IDLE, pending write dropped, no ack.
- dat_o holds its last read value between acks.

Optional Feature:
- Macro WB_MEM_ERR_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0).
  - A request with idx before truncation >= depth, or with adr_i < MEM_BASE, runs the same wait timing.
  - It then pulses err_o instead of ack_o in the ACK cycle, performs no write, and sets dat_o to 0.
  - ack_o and err_o are never high together.
- Undefined: no err_o port; out-of-range addresses wrap as described above.

Test Plan:
- Reset then read, WAIT_STATES=1: rst low for 3 cycles, then cyc=1 with a one-cycle stb, adr=32'h10, we=0 -> ack_o high exactly at edge N+2 for one cycle; dat_o = preloaded mem[4]; busy_o high from N+1 to N+2.
- Byte-lane write:
  - Preload mem[2]=32'h11223344.
  - Write adr=32'h8, sel=4'b0101, dat_i=32'hAABBCCDD, then read adr=32'h8.
  - -> second ack returns dat_o=32'h11BB33DD.
- Abort: start write of 32'hDEADBEEF to adr 0 with WAIT_STATES=3, drop cyc_i after 1 cycle -> no ack_o; a subsequent read of adr 0 returns the old value.
- Back-to-back plus ignored strobe: WAIT_STATES=0, pulse stb in the IDLE cycle and again during the ACK cycle -> only one ack; the next request is accepted only from IDLE, so acks are at least 2 cycles apart.
- Async reset mid-transfer: drop rst between clock edges while in WAIT -> ack_o=0 and busy_o=0 immediately; a pending write to adr 32'h4 is not committed.
- WB_MEM_ERR_EN build, ADDR_W=4: read adr=32'h40 -> err_o pulses at N+1+WAIT_STATES, ack_o stays 0, dat_o=0; write to adr 32'h40 leaves mem[0] unchanged.
